// File: rtl/pet_cpu_sched_pkg.sv
// Shared scheduler definitions: FSM state encodings for the CPU/video cycle scheduler.
package pet_cpu_sched_pkg;

  typedef enum logic [1:0] {
    SCH_RUN     = 2'd0,
    SCH_STOPPED = 2'd1,
    SCH_STEP    = 2'd2
  } sch_state_t;

endpackage

// File: rtl/pet_cpu_sched_sync2.sv
// Two-flop synchroniser for asynchronous front-panel switches, cleared by sync reset.
// Latency: 2 cycles from d to q. No flow control.
module pet_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pet_cpu_sched.sv
// Shares the 6502 cycle and video-RAM port: issues rdy (divided, turbo, stop, single-step) and video grants.
// Latency: 1 cycle from decision to rdy/vid_gnt. vid_req is held by the requester until granted.
module pet_cpu_sched
  import pet_cpu_sched_pkg::*;
#(
  parameter int CLK_DIV = 50,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_speed,
  input  logic             clk_stop,
  input  logic             step,
  input  logic             vid_req,
  output logic             rdy,
  output logic             vid_gnt,
  output logic [CNT_W-1:0] cpu_cycles
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             spd_s;
  logic             stop_s;
  logic             step_s;
  logic             step_d;
  logic             step_edge;
  logic [DIV_W-1:0] div_cnt;
  sch_state_t       state;
  sch_state_t       state_nxt;
  logic             slot;
  logic             run_ok;
  logic             cpu_go;
  logic             last_vid;

  pet_sync2 u_sync_spd (
    .clk   (clk),
    .reset (reset),
    .d     (clk_speed),
    .q     (spd_s)
  );

  pet_sync2 u_sync_stop (
    .clk   (clk),
    .reset (reset),
    .d     (clk_stop),
    .q     (stop_s)
  );

  pet_sync2 u_sync_step (
    .clk   (clk),
    .reset (reset),
    .d     (step),
    .q     (step_s)
  );

  assign step_edge = step_s & ~step_d;

  // The registered grant doubles as the "video had the port last cycle" flag.
  assign last_vid = vid_gnt;

  always_comb begin
    slot = 1'b0;
    if (spd_s) begin
      slot = ~(vid_req & ~last_vid);
    end else begin
      slot = (div_cnt == DIV_LAST);
    end
  end

  assign run_ok = ((state == SCH_RUN) & ~stop_s) | (state == SCH_STEP);
  assign cpu_go = run_ok & slot;

  always_comb begin
    state_nxt = state;
    case (state)
      SCH_RUN: begin
        if (stop_s) state_nxt = SCH_STOPPED;
      end
      SCH_STOPPED: begin
        if (!stop_s) state_nxt = SCH_RUN;
        else if (step_edge) state_nxt = SCH_STEP;
      end
      SCH_STEP: begin
        // Leave only once the single stepped cycle has actually been issued.
        if (cpu_go) state_nxt = stop_s ? SCH_STOPPED : SCH_RUN;
      end
      default: state_nxt = SCH_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SCH_RUN;
      div_cnt    <= '0;
      step_d     <= 1'b0;
      rdy        <= 1'b0;
      vid_gnt    <= 1'b0;
      cpu_cycles <= '0;
    end else begin
      state   <= state_nxt;
      step_d  <= step_s;
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      rdy     <= cpu_go;
      vid_gnt <= vid_req & ~cpu_go;
      if (rdy) cpu_cycles <= cpu_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pet_cpu_sched.sv
// Directed bench for pet_cpu_sched: vector table plus hand sequences for stop, step, turbo, reset.
module tb_pet_cpu_sched;

  logic        clk;
  logic        reset, clk_speed, clk_stop, step, vid_req;
  logic        rdy, vid_gnt;
  logic [31:0] cpu_cycles;

  logic        reset2, spd2, stop2, step2, vreq2;
  logic        rdy2, gnt2;
  logic [31:0] cyc2;

  logic        zero3;
  logic        rdy3, gnt3;
  logic [1:0]  cyc3;

  int checks   = 0;
  int failures = 0;

  pet_cpu_sched #(.CLK_DIV(4), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_speed  (clk_speed),
    .clk_stop   (clk_stop),
    .step       (step),
    .vid_req    (vid_req),
    .rdy        (rdy),
    .vid_gnt    (vid_gnt),
    .cpu_cycles (cpu_cycles)
  );

  pet_cpu_sched #(.CLK_DIV(50), .CNT_W(32)) dut50 (
    .clk        (clk),
    .reset      (reset2),
    .clk_speed  (spd2),
    .clk_stop   (stop2),
    .step       (step2),
    .vid_req    (vreq2),
    .rdy        (rdy2),
    .vid_gnt    (gnt2),
    .cpu_cycles (cyc2)
  );

  pet_cpu_sched #(.CLK_DIV(2), .CNT_W(2)) dutw (
    .clk        (clk),
    .reset      (reset),
    .clk_speed  (zero3),
    .clk_stop   (zero3),
    .step       (zero3),
    .vid_req    (zero3),
    .rdy        (rdy3),
    .vid_gnt    (gnt3),
    .cpu_cycles (cyc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst;
    logic vreq;
    logic e_rdy;
    logic e_gnt;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int   cnt;
    logic prev;

    // {reset, vid_req, expected rdy, expected vid_gnt} per clock, normal mode, CLK_DIV=4
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; clk_speed = 1'b0; clk_stop = 1'b0; step = 1'b0; vid_req = 1'b0;
    reset2 = 1'b1; spd2 = 1'b0; stop2 = 1'b0; step2 = 1'b0; vreq2 = 1'b0;
    zero3 = 1'b0;

    tick();
    chk1("reset_rdy", rdy, 1'b0);
    chk1("reset_gnt", vid_gnt, 1'b0);
    chk32("reset_cycles", cpu_cycles, 32'd0);

    for (int i = 0; i < 12; i++) begin
      reset   = tbl[i].rst;
      vid_req = tbl[i].vreq;
      tick();
      chk1($sformatf("vec%0d_rdy", i), rdy, tbl[i].e_rdy);
      chk1($sformatf("vec%0d_gnt", i), vid_gnt, tbl[i].e_gnt);
    end

    // Normal cadence: rdy on every 4th clock after release, counter lags rdy by one clock.
    vid_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      chk1($sformatf("cadence_e%0d", k), rdy, (k % 4) == 0);
    end
    tick();
    chk32("cycles_after_100", cpu_cycles, 32'd25);
    chk32("wrap_cycles", 32'(cyc3), 32'd2);
    chk1("wrap_no_gnt", gnt3, 1'b0);

    // Video held: it owns every clock the CPU does not.
    vid_req = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk1("vid_excl", vid_gnt, ~rdy);
      cnt = cnt + (rdy ? 1 : 0);
    end
    chk32("vid_rdy_count", 32'(cnt), 32'd10);
    vid_req = 1'b0;

    // Turbo.
    clk_speed = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k >= 4) chk1($sformatf("turbo_e%0d", k), rdy, 1'b1);
    end
    vid_req = 1'b1;
    tick();
    tick();
    prev = rdy;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk1("turbo_share_excl", rdy ^ vid_gnt, 1'b1);
      chk1("turbo_alternate", rdy, ~prev);
      prev = rdy;
    end
    vid_req = 1'b0;
    clk_speed = 1'b0;

    // Stop, then single-step with a pulse and with a held button.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    clk_stop = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      cnt = cnt + (rdy ? 1 : 0);
    end
    chk1("stop_tail_le1", cnt <= 1, 1'b1);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      cnt = cnt + (rdy ? 1 : 0);
    end
    chk32("stopped_rdy", 32'(cnt), 32'd0);

    cnt = 0;
    step = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (k == 2) step = 1'b0;
      cnt = cnt + (rdy ? 1 : 0);
    end
    chk32("step_pulse_rdy", 32'(cnt), 32'd1);

    cnt = 0;
    step = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      cnt = cnt + (rdy ? 1 : 0);
    end
    chk32("step_held_rdy", 32'(cnt), 32'd1);
    step = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      cnt = cnt + (rdy ? 1 : 0);
    end
    chk32("step_release_rdy", 32'(cnt), 32'd0);

    // Step taken while the stop switch is released before the slot: step rdy then RUN cadence.
    clk_stop = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 3) step = 1'b1;
      if (k == 5) clk_stop = 1'b0;
      chk1($sformatf("step_run_e%0d", k), rdy, (k >= 8) && ((k % 4) == 0));
    end
    tick();
    chk32("step_run_cycles", cpu_cycles, 32'd5);
    step = 1'b0;

    // CLK_DIV=50: reset while a step is pending.
    tick();
    reset2 = 1'b0;
    for (int k = 0; k < 101; k++) tick();
    chk32("div50_cycles", cyc2, 32'd2);
    stop2 = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 3) step2 = 1'b1;
      if (k == 6) step2 = 1'b0;
      cnt = cnt + (rdy2 ? 1 : 0);
    end
    chk32("div50_pending_step", 32'(cnt), 32'd0);
    reset2 = 1'b1;
    stop2 = 1'b0;
    tick();
    chk1("div50_rst_rdy", rdy2, 1'b0);
    chk1("div50_rst_gnt", gnt2, 1'b0);
    chk32("div50_rst_cycles", cyc2, 32'd0);
    reset2 = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk1($sformatf("div50_e%0d", k), rdy2, k == 50);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
